// File: rtl/signal_mixer_if.sv
// Voice-mixer bus between the wave shapers / PWM stage and signal_mixer.
// master drives voices and control, slave returns the mixed sample.
interface signal_mixer_if #(
    parameter int NUM_VOICES = 4
);
    logic                    sample_req;
    logic [8*NUM_VOICES-1:0] voice_in;
    logic [NUM_VOICES-1:0]   voice_en;
    logic [1:0]              atten;
    logic                    clr_ovr;
    logic [7:0]              final_out;
    logic                    start;
    logic                    busy;
    logic                    overrun;

    modport master (
        output sample_req, voice_in, voice_en, atten, clr_ovr,
        input  final_out, start, busy, overrun
    );

    modport slave (
        input  sample_req, voice_in, voice_en, atten, clr_ovr,
        output final_out, start, busy, overrun
    );
endinterface

// File: rtl/signal_mixer.sv
// Sequential voice mixer: snapshot, accumulate one voice per cycle,
// attenuate, saturate, then strobe the result to the PWM stage.
module signal_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = 11
) (
    input logic           clk,
    input logic           rst,
    signal_mixer_if.slave bus
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [8*NUM_VOICES-1:0] snap_voice_q, snap_voice_d;
    logic [NUM_VOICES-1:0]   snap_en_q, snap_en_d;
    logic [1:0]              snap_atten_q, snap_atten_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              final_q, final_d;
    logic                    overrun_q, overrun_d;

    logic [7:0]              cur_sample;
    logic signed [7:0]       cur_signed;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] sat;
    logic                    busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.sample_req) state_d = ACCUM;
            ACCUM:   if (idx_q == LAST) state_d = SCALE;
            SCALE:   state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        bus.busy  = busy;
        bus.start = (state_q == OUT);
    end

    // Offset-binary to two's complement is just an MSB flip.
    always_comb begin
        cur_sample = snap_voice_q[idx_q*8 +: 8];
        cur_signed = $signed({~cur_sample[7], cur_sample[6:0]});
        shifted    = acc_q >>> snap_atten_q;
        if (shifted > SAT_HI)      sat = SAT_HI;
        else if (shifted < SAT_LO) sat = SAT_LO;
        else                       sat = shifted;
    end

    always_comb begin
        snap_voice_d = snap_voice_q;
        snap_en_d    = snap_en_q;
        snap_atten_d = snap_atten_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        final_d      = final_q;
        unique case (state_q)
            IDLE: begin
                if (bus.sample_req) begin
                    snap_voice_d = bus.voice_in;
                    snap_en_d    = bus.voice_en;
                    snap_atten_d = bus.atten;
                    idx_d        = '0;
                    acc_d        = '0;
                end
            end
            ACCUM: begin
                if (snap_en_q[idx_q]) acc_d = acc_q + ACC_W'(cur_signed);
                idx_d = idx_q + 1'b1;
            end
            SCALE:   final_d = {~sat[7], sat[6:0]};
            default: ;
        endcase
    end

    // A new overrun outranks a coincident clear.
    always_comb begin
        overrun_d = overrun_q;
        if (bus.sample_req && busy) overrun_d = 1'b1;
        else if (bus.clr_ovr)       overrun_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_voice_q <= '0;
            snap_en_q    <= '0;
            snap_atten_q <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            final_q      <= 8'd128;
            overrun_q    <= 1'b0;
        end else begin
            snap_voice_q <= snap_voice_d;
            snap_en_q    <= snap_en_d;
            snap_atten_q <= snap_atten_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            final_q      <= final_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.final_out = final_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_signal_mixer.sv
// Directed bench for signal_mixer: vector table of single mixes plus
// hand-written overrun and mid-mix reset sequences.
module tb_signal_mixer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    signal_mixer_if #(.NUM_VOICES(4)) bus ();

    signal_mixer #(.NUM_VOICES(4), .ACC_W(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] v;
        logic [3:0]  en;
        logic [1:0]  at;
        logic        sc;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mix(input vec_t t);
        int n;
        tick();
        bus.voice_in   = t.v;
        bus.voice_en   = t.en;
        bus.atten      = t.at;
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        n = 1;
        chk({t.name, " busy_T+1"}, 32'(bus.busy), 1);
        while (!bus.start && n < 20) begin
            if (t.sc && n == 2) bus.voice_in = '1;
            if (n == 5) chk({t.name, " busy_T+5"}, 32'(bus.busy), 1);
            tick();
            n++;
        end
        chk({t.name, " latency"}, 32'(n), 6);
        chk({t.name, " final_out"}, 32'(bus.final_out), 32'(t.exp));
        tick();
        chk({t.name, " start_width"}, 32'(bus.start), 0);
        chk({t.name, " busy_idle"}, 32'(bus.busy), 0);
        chk({t.name, " hold"}, 32'(bus.final_out), 32'(t.exp));
    endtask

    int starts;

    initial begin
        tbl[0]  = '{32'h80808080, 4'b0000, 2'd0, 1'b0, 8'd128, "none"};
        tbl[1]  = '{32'h808080C8, 4'b0001, 2'd0, 1'b0, 8'd200, "single_a0"};
        tbl[2]  = '{32'h808080C8, 4'b0001, 2'd1, 1'b0, 8'd164, "single_a1"};
        tbl[3]  = '{32'hFFFFFFFF, 4'b1111, 2'd0, 1'b0, 8'd255, "pos_a0"};
        tbl[4]  = '{32'hFFFFFFFF, 4'b1111, 2'd2, 1'b0, 8'd255, "pos_a2"};
        tbl[5]  = '{32'hFFFFFFFF, 4'b1111, 2'd3, 1'b0, 8'd191, "pos_a3"};
        tbl[6]  = '{32'h00000000, 4'b1111, 2'd0, 1'b0, 8'd0,   "neg_a0"};
        tbl[7]  = '{32'h00000000, 4'b1111, 2'd3, 1'b1, 8'd64,  "neg_a3_snap"};
        tbl[8]  = '{32'h3C8064C8, 4'b1011, 2'd0, 1'b0, 8'd104, "mixed_a0"};
        tbl[9]  = '{32'h3C8064C8, 4'b1011, 2'd1, 1'b0, 8'd116, "mixed_a1"};
        tbl[10] = '{32'h80807E7F, 4'b0011, 2'd1, 1'b0, 8'd126, "round_neg"};

        bus.sample_req = 1'b0;
        bus.voice_in   = '0;
        bus.voice_en   = '0;
        bus.atten      = '0;
        bus.clr_ovr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst final_out", 32'(bus.final_out), 128);
        chk("rst start", 32'(bus.start), 0);
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst overrun", 32'(bus.overrun), 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_mix(tbl[i]);

        // overrun: req at c0 and c2, clear at c10
        bus.voice_in = 32'h808080C8;
        bus.voice_en = 4'b0001;
        bus.atten    = 2'd0;
        starts = 0;
        for (int c = 0; c <= 14; c++) begin
            if (c == 2)  chk("ovr c2", 32'(bus.overrun), 0);
            if (c == 3)  chk("ovr c3", 32'(bus.overrun), 1);
            if (c == 10) chk("ovr c10", 32'(bus.overrun), 1);
            if (c == 11) chk("ovr c11", 32'(bus.overrun), 0);
            if (c == 6)  chk("ovr start c6", 32'(bus.start), 1);
            if (bus.start) starts++;
            bus.sample_req = (c == 0 || c == 2);
            bus.clr_ovr    = (c == 10);
            tick();
        end
        chk("ovr starts", 32'(starts), 1);

        // clear coincident with a busy request: set wins
        starts = 0;
        for (int c = 0; c <= 10; c++) begin
            if (c == 5) chk("ovr set_wins", 32'(bus.overrun), 1);
            if (bus.start) starts++;
            bus.sample_req = (c == 0 || c == 2 || c == 4);
            bus.clr_ovr    = (c == 4);
            tick();
        end
        chk("ovr2 starts", 32'(starts), 1);
        chk("ovr2 held", 32'(bus.overrun), 1);
        chk("ovr2 final_out", 32'(bus.final_out), 200);

        // reset during ACCUM aborts the mix with no strobe
        bus.voice_in = 32'hFFFFFFFF;
        bus.voice_en = 4'b1111;
        starts = 0;
        for (int c = 0; c <= 10; c++) begin
            if (c == 3) begin
                rst = 1'b1;
                #1;
                chk("mid_rst final_out", 32'(bus.final_out), 128);
                chk("mid_rst busy", 32'(bus.busy), 0);
                chk("mid_rst overrun", 32'(bus.overrun), 0);
            end
            if (c == 5) rst = 1'b0;
            if (bus.start) starts++;
            bus.sample_req = (c == 0);
            tick();
        end
        chk("mid_rst starts", 32'(starts), 0);
        chk("mid_rst idle out", 32'(bus.final_out), 128);
        run_mix(tbl[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
